rf_wb_arbiter: RTL and testbench

//   Shares the register file's single write port among NUM_REQ writeback sources (ALU, load unit, ...).

---
 rtl/rf_ctrl_pkg.sv | 10 +
 rtl/rf_wb_arbiter_rr.sv | 22 ++
 rtl/rf_wb_arbiter.sv | 81 ++++++++
 tb/tb_rf_wb_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: register-file geometry shared by the write-port arbiter and other writeback producers.
package rf_ctrl_pkg;
  localparam int unsigned REG_ADDR_W = 6;
  localparam int unsigned REG_DATA_W = 64;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ZERO   = 0;
  function automatic logic wr_legal(input int unsigned a);
    return a != REG_ZERO && a < NUM_REGS;
  endfunction
endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// rr_arbiter: combinational round-robin grant; the lowest wrap-around distance from ptr wins.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt
);
  int best;
  int bi;
  always_comb begin
    best = NUM_REQ;
    bi = 0;
    gnt = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (req[i] && ((i + NUM_REQ - int'(ptr)) % NUM_REQ) < best) begin
        best = (i + NUM_REQ - int'(ptr)) % NUM_REQ;
        bi = i;
      end
    for (int i = 0; i < NUM_REQ; i++) gnt[i] = (best < NUM_REQ) && (bi == i);
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin share of the register-file write port; RF_WB_BYPASS_EN adds read forwarding.
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  input  logic [ADDR_W-1:0]         rd_addr1,
  input  logic [ADDR_W-1:0]         rd_addr2,
  input  logic [DATA_W-1:0]         rf_data1,
  input  logic [DATA_W-1:0]         rf_data2,
  output logic [DATA_W-1:0]         byp_data1,
  output logic [DATA_W-1:0]         byp_data2,
  output logic                      err_addr
);
  localparam int PW = $clog2(NUM_REQ);
  logic [PW-1:0] ptr_q, ptr_d, win;
  logic [NUM_REQ-1:0] gnt;
  logic xfer;
  logic [ADDR_W-1:0] w_addr, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] w_data, wr_data_q, wr_data_d;
  logic wr_en_q, wr_en_d, err_q, err_d;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (.req(req_valid), .ptr(ptr_q), .gnt(gnt));
  assign req_ready = rst ? '0 : gnt;
  assign xfer = |(req_valid & req_ready);
  always_comb begin
    win = '0;
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) begin
        win = PW'(i);
        w_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_data = req_data[i*DATA_W +: DATA_W];
      end
  end
  // r0 and out-of-range targets are consumed without a write; the latter set the sticky error
  always_comb begin
    ptr_d = xfer ? (win == PW'(NUM_REQ - 1) ? '0 : win + PW'(1)) : ptr_q;
    wr_en_d = xfer && wr_legal(32'(w_addr));
    wr_addr_d = xfer ? w_addr : wr_addr_q;
    wr_data_d = xfer ? w_data : wr_data_q;
    err_d = err_q | (xfer && 32'(w_addr) >= NUM_REGS);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q <= err_d;
    end
  end
  assign wr_en = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign err_addr = err_q;
`ifdef RF_WB_BYPASS_EN
  assign byp_data1 = (wr_en_q && wr_addr_q == rd_addr1 && rd_addr1 != ADDR_W'(REG_ZERO)) ? wr_data_q : rf_data1;
  assign byp_data2 = (wr_en_q && wr_addr_q == rd_addr2 && rd_addr2 != ADDR_W'(REG_ZERO)) ? wr_data_q : rf_data2;
`else
  assign byp_data1 = rf_data1;
  assign byp_data2 = rf_data2;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: vector table, hand sequences and randomized model check of rf_wb_arbiter.
module tb_rf_wb_arbiter;
  import rf_ctrl_pkg::*;
  localparam int N = 2;
  localparam int AW = REG_ADDR_W;
  localparam int DW = REG_DATA_W;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic wr_en, err_addr;
  logic [AW-1:0] wr_addr, rd_addr1, rd_addr2;
  logic [DW-1:0] wr_data, rf_data1, rf_data2, byp_data1, byp_data2;
  logic [DW-1:0] rf [32];
  int n_checks = 0;
  int n_fail = 0;
  bit byp_on;
  typedef struct {
    bit rst;
    logic [1:0] v;
    logic [5:0] a0, a1;
    logic [63:0] d0, d1;
    logic [1:0] rdy;
    logic en;
    logic [5:0] addr;
    logic [63:0] data;
    logic err;
  } vec_t;
  vec_t tv [15];
  always #5 clk = ~clk;
  always @(posedge clk) if (wr_en) rf[wr_addr[4:0]] <= wr_data;
  rf_wb_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rf_data1(rf_data1),
    .rf_data2(rf_data2), .byp_data1(byp_data1), .byp_data2(byp_data2), .err_addr(err_addr)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(bit r, logic [1:0] v, logic [5:0] a0, logic [5:0] a1, logic [63:0] d0,
                              logic [63:0] d1, logic [1:0] rdy, logic en, logic [5:0] ad,
                              logic [63:0] dt, logic e);
    vec_t t;
    t.rst = r; t.v = v; t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
    t.rdy = rdy; t.en = en; t.addr = ad; t.data = dt; t.err = e;
    return t;
  endfunction
  task automatic drive(input bit r, input logic [1:0] v, input logic [5:0] a0, input logic [5:0] a1,
                       input logic [63:0] d0, input logic [63:0] d1);
    rst = r;
    req_valid = v;
    req_addr[0 +: AW] = a0;
    req_addr[AW +: AW] = a1;
    req_data[0 +: DW] = d0;
    req_data[DW +: DW] = d1;
  endtask
  task automatic chk_out(input string nm, input logic en, input logic [5:0] ad, input logic [63:0] dt, input logic e);
    chk({nm, " wr_en"}, 64'(wr_en), 64'(en));
    chk({nm, " wr_addr"}, 64'(wr_addr), 64'(ad));
    chk({nm, " wr_data"}, wr_data, dt);
    chk({nm, " err_addr"}, 64'(err_addr), 64'(e));
  endtask
  initial begin
    int mptr;
    logic men, merr;
    logic [5:0] maddr;
    logic [63:0] mdata;
    bit pend [N];
    logic [5:0] pa [N];
    logic [63:0] pd [N];
`ifdef RF_WB_BYPASS_EN
    byp_on = 1'b1;
`else
    byp_on = 1'b0;
`endif
    tv[0]  = mk(1, 2'b11, 1, 2, 64'h1, 64'h2, 2'b00, 0, 0, 64'h0, 0);
    tv[1]  = mk(0, 2'b01, 5, 0, 64'hDEAD_BEEF, 64'h0, 2'b01, 1, 5, 64'hDEAD_BEEF, 0);
    tv[2]  = mk(0, 2'b00, 0, 0, 64'h0, 64'h0, 2'b00, 0, 5, 64'hDEAD_BEEF, 0);
    tv[3]  = mk(1, 2'b00, 0, 0, 64'h0, 64'h0, 2'b00, 0, 0, 64'h0, 0);
    tv[4]  = mk(0, 2'b11, 10, 11, 64'h100, 64'h111, 2'b01, 1, 10, 64'h100, 0);
    tv[5]  = mk(0, 2'b11, 12, 11, 64'h102, 64'h111, 2'b10, 1, 11, 64'h111, 0);
    tv[6]  = mk(0, 2'b11, 12, 13, 64'h102, 64'h113, 2'b01, 1, 12, 64'h102, 0);
    tv[7]  = mk(0, 2'b11, 14, 13, 64'h104, 64'h113, 2'b10, 1, 13, 64'h113, 0);
    tv[8]  = mk(0, 2'b01, 0, 0, 64'h77, 64'h0, 2'b01, 0, 0, 64'h77, 0);
    tv[9]  = mk(0, 2'b10, 0, 40, 64'h0, 64'h88, 2'b10, 0, 40, 64'h88, 1);
    tv[10] = mk(0, 2'b00, 0, 0, 64'h0, 64'h0, 2'b00, 0, 40, 64'h88, 1);
    tv[11] = mk(0, 2'b01, 31, 0, 64'h31, 64'h0, 2'b01, 1, 31, 64'h31, 1);
    tv[12] = mk(0, 2'b10, 0, 32, 64'h0, 64'h32, 2'b10, 0, 32, 64'h32, 1);
    tv[13] = mk(0, 2'b10, 0, 1, 64'h0, 64'h1, 2'b10, 1, 1, 64'h1, 1);
    tv[14] = mk(1, 2'b11, 9, 9, 64'h9, 64'h9, 2'b00, 0, 0, 64'h0, 0);
    rd_addr1 = '0; rd_addr2 = '0; rf_data1 = '0; rf_data2 = '0;
    drive(1, 2'b00, 0, 0, 0, 0);
    @(posedge clk); #1;
    for (int r = 0; r < 15; r++) begin
      drive(tv[r].rst, tv[r].v, tv[r].a0, tv[r].a1, tv[r].d0, tv[r].d1);
      #2;
      chk($sformatf("tv%0d req_ready", r), 64'(req_ready), 64'(tv[r].rdy));
      @(posedge clk); #1;
      chk_out($sformatf("tv%0d", r), tv[r].en, tv[r].addr, tv[r].data, tv[r].err);
    end
    drive(0, 2'b10, 0, 3, 0, 64'hA);
    #2 chk("ord src1 ready", 64'(req_ready), 64'(2'b10));
    @(posedge clk); #1;
    drive(0, 2'b01, 3, 0, 64'hB, 0);
    #2 chk("ord src0 ready", 64'(req_ready), 64'(2'b01));
    @(posedge clk); #1;
    chk_out("ord second", 1, 3, 64'hB, 0);
    drive(0, 2'b01, 7, 0, 64'h55, 0);
    @(posedge clk); #1;
    chk("ord rf r3", rf[3], 64'hB);
    drive(0, 2'b00, 0, 0, 0, 0);
    rd_addr1 = 7; rf_data1 = 64'h11; rd_addr2 = 0; rf_data2 = 64'h22;
    #2;
    chk("byp1 hit", byp_data1, byp_on ? 64'h55 : 64'h11);
    chk("byp2 r0", byp_data2, 64'h22);
    rd_addr2 = 7;
    #1 chk("byp2 hit", byp_data2, byp_on ? 64'h55 : 64'h22);
    @(posedge clk); #1;
    chk("byp1 after window", byp_data1, 64'h11);
    drive(1, 2'b00, 0, 0, 0, 0);
    @(posedge clk); #1;
    mptr = 0; men = 0; maddr = 0; mdata = 0; merr = 0;
    for (int i = 0; i < N; i++) begin pend[i] = 0; pa[i] = 0; pd[i] = 0; end
    for (int c = 0; c < 3000; c++) begin
      bit r;
      int g;
      logic [N-1:0] er;
      logic [63:0] e1, e2;
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1;
          pa[i] = 6'($urandom_range(0, 47));
          pd[i] = {$urandom, $urandom};
        end
      r = ($urandom_range(0, 63) == 0);
      drive(r, {pend[1], pend[0]}, pa[0], pa[1], pd[0], pd[1]);
      rd_addr1 = $urandom_range(0, 1) ? maddr : 6'($urandom_range(0, 47));
      rd_addr2 = $urandom_range(0, 1) ? maddr : 6'($urandom_range(0, 47));
      rf_data1 = {$urandom, $urandom};
      rf_data2 = {$urandom, $urandom};
      e1 = (byp_on && men && maddr == rd_addr1 && rd_addr1 != 0) ? mdata : rf_data1;
      e2 = (byp_on && men && maddr == rd_addr2 && rd_addr2 != 0) ? mdata : rf_data2;
      g = -1;
      if (!r)
        for (int k = 0; k < N; k++)
          if (g < 0 && pend[(mptr + k) % N]) g = (mptr + k) % N;
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      #2;
      chk($sformatf("rnd%0d req_ready", c), 64'(req_ready), 64'(er));
      chk($sformatf("rnd%0d byp1", c), byp_data1, e1);
      chk($sformatf("rnd%0d byp2", c), byp_data2, e2);
      @(posedge clk); #1;
      if (r) begin
        mptr = 0; men = 0; maddr = 0; mdata = 0; merr = 0;
      end else if (g >= 0) begin
        men = pa[g] != 0 && pa[g] < 32;
        maddr = pa[g];
        mdata = pd[g];
        merr = merr | (pa[g] >= 32);
        mptr = (g + 1) % N;
        pend[g] = 0;
      end else begin
        men = 0;
      end
      chk_out($sformatf("rnd%0d", c), men, maddr, mdata, merr);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
